alu_op_sequencer: RTL and testbench

- Sequences the 3-bit two-operand ALU for a single requester; the ALU is otherwise driven by hand-toggled load1/load2/run strobes.
- Accepts one command (A, B, op_code) on a valid/ready handshake.
- Generates the load1, load2 and run strobe pulses with programmable width, gap and settle times.
- Captures the ALU's 4-bit C output and returns it on a valid/ready result port.
- Skips operand reloads when an operand matches the value already held in the ALU.

---
 rtl/alu_op_sequencer_pkg.sv | 47 ++++
 rtl/alu_op_sequencer_if.sv | 47 ++++
 rtl/alu_op_sequencer_timer.sv | 38 +++
 rtl/alu_op_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and constants for the ALU operation sequencer:
//               FSM state encoding, ALU op_code values, phase-counter width
//               and a helper that converts a cycle count into a reload value.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  localparam int CNT_W = 4;

  typedef logic [3:0] op_t;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LD1  = 4'd1,
    GAP1 = 4'd2,
    LD2  = 4'd3,
    GAP2 = 4'd4,
    RUN  = 4'd5,
    GAP3 = 4'd6,
    WAIT = 4'd7,
    DONE = 4'd8
  } state_t;

  localparam op_t OP_ADD  = 4'b0000;
  localparam op_t OP_SUB  = 4'b0001;
  localparam op_t OP_MUL  = 4'b0010;
  localparam op_t OP_INC  = 4'b0011;
  localparam op_t OP_DEC  = 4'b0100;
  localparam op_t OP_AND  = 4'b0101;
  localparam op_t OP_OR   = 4'b0110;
  localparam op_t OP_XOR  = 4'b0111;
  localparam op_t OP_NOT  = 4'b1000;
  localparam op_t OP_SHL1 = 4'b1001;
  localparam op_t OP_SHR1 = 4'b1010;
  localparam op_t OP_MAX  = 4'b1010;

  // A phase lasting W cycles exits when the down-counter reaches zero, so it
  // is loaded with W-1 on entry.
  function automatic logic [CNT_W-1:0] cnt_val(input int w);
    return CNT_W'(w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer_if
// Description : Command, result and ALU-side signals of the sequencer.
//               slave  : sequencer view (accepts commands, drives the ALU)
//               master : requester + ALU view (issues commands, returns C)
// Ports       : cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op   command handshake
//               res_valid/res_ready/res_data/res_err     result handshake
//               alu_a/alu_b/alu_op_code/alu_load1/alu_load2/alu_run/alu_c
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if;
  import alu_seq_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_a;
  logic [2:0] cmd_b;
  op_t        cmd_op;

  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_err;

  logic [2:0] alu_a;
  logic [2:0] alu_b;
  op_t        alu_op_code;
  logic       alu_load1;
  logic       alu_load2;
  logic       alu_run;
  logic [3:0] alu_c;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready, alu_c,
    output cmd_ready, res_valid, res_data, res_err,
           alu_a, alu_b, alu_op_code, alu_load1, alu_load2, alu_run
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready, alu_c,
    input  cmd_ready, res_valid, res_data, res_err,
           alu_a, alu_b, alu_op_code, alu_load1, alu_load2, alu_run
  );

endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer_timer.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_timer
// Description : Loadable down-counter that times every sequencer phase.
//               Saturates at zero; o_zero marks the last cycle of a phase.
// Ports       : clk, rst         clock, async active-high reset
//               i_load/i_load_val reload the count (wins over enable)
//               i_en              decrement enable
//               o_zero            count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_timer
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Drives a 3-bit two-operand ALU from a single command port.
//               Issues load1/load2/run strobes with programmable pulse, gap
//               and settle times, returns the captured C output, and skips
//               an operand load when the ALU already holds that value.
// Ports       : clk     clock, rising edge
//               reset   asynchronous active-high reset
//               bus     command/result handshakes and ALU-side signals
//               busy    sequencer not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PULSE_W  = 1,
  parameter int GAP_W    = 1,
  parameter int SETTLE_W = 2,
  parameter int CACHE_EN = 1
) (
  input  logic                clk,
  input  logic                reset,
  alu_op_sequencer_if.slave   bus,
  output logic                busy
);

  localparam logic [CNT_W-1:0] c_pulse  = cnt_val(PULSE_W);
  localparam logic [CNT_W-1:0] c_gap    = cnt_val(GAP_W);
  localparam logic [CNT_W-1:0] c_settle = cnt_val(SETTLE_W);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] w_cnt_load;
  logic             w_zero;

  logic [2:0]       r_alu_a, r_alu_b;
  op_t              r_alu_op;
  logic [2:0]       r_a_cache, r_b_cache;
  logic             r_a_vld, r_b_vld;
  logic             r_load1, r_load2, r_run;
  logic             r_cmd_ready, r_res_valid, r_res_err, r_busy;
  logic [3:0]       r_res_data;

  logic             w_accept, w_illegal;
  logic             w_a_hit_cmd, w_b_hit_cmd, w_b_hit_reg;

  assign w_accept    = (r_state == IDLE) && r_cmd_ready && bus.cmd_valid;
  assign w_illegal   = (bus.cmd_op > OP_MAX);
  assign w_a_hit_cmd = (CACHE_EN != 0) && r_a_vld && (bus.cmd_a == r_a_cache);
  assign w_b_hit_cmd = (CACHE_EN != 0) && r_b_vld && (bus.cmd_b == r_b_cache);
  // After the A load the command is already registered, so B is checked
  // against the registered operand rather than the (possibly changed) port.
  assign w_b_hit_reg = (CACHE_EN != 0) && r_b_vld && (r_alu_b == r_b_cache);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_illegal)         w_next = DONE;
          else if (!w_a_hit_cmd) w_next = LD1;
          else if (!w_b_hit_cmd) w_next = LD2;
          else                   w_next = RUN;
        end
      end
      LD1:  if (w_zero) w_next = GAP1;
      GAP1: if (w_zero) w_next = w_b_hit_reg ? RUN : LD2;
      LD2:  if (w_zero) w_next = GAP2;
      GAP2: if (w_zero) w_next = RUN;
      RUN:  if (w_zero) w_next = GAP3;
      GAP3: if (w_zero) w_next = WAIT;
      WAIT: if (w_zero) w_next = DONE;
      DONE: if (bus.res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_load = '0;
    case (w_next)
      LD1, LD2, RUN:    w_cnt_load = c_pulse;
      GAP1, GAP2, GAP3: w_cnt_load = c_gap;
      WAIT:             w_cnt_load = c_settle;
      default:          w_cnt_load = '0;
    endcase
  end

  // Reload on every state change; no state ever transitions to itself.
  alu_seq_timer u_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_next != r_state),
    .i_en       (1'b1),
    .i_load_val (w_cnt_load),
    .o_zero     (w_zero)
  );

  // Strobes and status are registered from the next state so the ALU sees
  // glitch-free edges and everything drops together on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_a_cache   <= '0;
      r_b_cache   <= '0;
      r_a_vld     <= 1'b0;
      r_b_vld     <= 1'b0;
      r_load1     <= 1'b0;
      r_load2     <= 1'b0;
      r_run       <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_err   <= 1'b0;
      r_res_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cmd_ready <= (w_next == IDLE);
      r_busy      <= (w_next != IDLE);
      r_res_valid <= (w_next == DONE);
      r_load1     <= (w_next == LD1);
      r_load2     <= (w_next == LD2);
      r_run       <= (w_next == RUN);

      if (w_accept) begin
        r_alu_a  <= bus.cmd_a;
        r_alu_b  <= bus.cmd_b;
        r_alu_op <= bus.cmd_op;
        if (w_illegal) begin
          r_res_data <= '0;
          r_res_err  <= 1'b1;
        end
      end

      // The ALU captured the operand on the strobe's falling edge, so the
      // cache is only trusted once the following gap has completed.
      if ((r_state == GAP1) && w_zero) begin
        r_a_cache <= r_alu_a;
        r_a_vld   <= 1'b1;
      end
      if ((r_state == GAP2) && w_zero) begin
        r_b_cache <= r_alu_b;
        r_b_vld   <= 1'b1;
      end

      if ((r_state == WAIT) && w_zero) begin
        r_res_data <= bus.alu_c;
        r_res_err  <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_data    = r_res_data;
  assign bus.res_err     = r_res_err;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_op_code = r_alu_op;
  assign bus.alu_load1   = r_load1;
  assign bus.alu_load2   = r_load2;
  assign bus.alu_run     = r_run;
  assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Scoreboard bench for alu_op_sequencer. Instance 0 has the
//               operand cache enabled, instance 1 has it disabled. A small
//               behavioural ALU captures on strobe falling edges. Expected
//               results are pushed at issue time and popped by a per-instance
//               monitor when a result is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  typedef struct {
    logic [3:0] data;
    logic       err;
    int         lat;
    int         l1c;
    int         l2c;
    int         rnc;
    int         n1;
    int         n2;
    int         nr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst       = 2'b11;
  logic [1:0]       cmd_valid = 2'b00;
  logic [1:0][2:0]  cmd_a;
  logic [1:0][2:0]  cmd_b;
  logic [1:0][3:0]  cmd_op;
  logic [1:0]       res_ready = 2'b11;

  logic [1:0]       rdy_obs;
  logic [1:0]       busy_obs;
  logic [1:0][2:0]  stb_obs;
  logic [1:0][20:0] out_obs;

  exp_t sb_q [2][$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] data, input logic err, input int lat,
                              input int l1c, input int l2c, input int rnc,
                              input int n1, input int n2, input int nr);
    exp_t e;
    e.data = data; e.err = err; e.lat = lat;
    e.l1c = l1c; e.l2c = l2c; e.rnc = rnc;
    e.n1 = n1; e.n2 = n2; e.nr = nr;
    return e;
  endfunction

  function automatic logic [3:0] alu_f(input logic [2:0] a, input logic [2:0] b, input logic [3:0] op);
    case (op)
      OP_ADD:  alu_f = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu_f = {1'b0, a} - {1'b0, b};
      OP_MUL:  alu_f = {1'b0, a} * {1'b0, b};
      OP_AND:  alu_f = {1'b0, a & b};
      OP_OR:   alu_f = {1'b0, a | b};
      OP_XOR:  alu_f = {1'b0, a ^ b};
      default: alu_f = 4'h0;
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    alu_op_sequencer_if bus ();
    logic       busy;
    logic [2:0] ra = '0;
    logic [2:0] rb = '0;
    logic [3:0] rc = '0;

    assign bus.cmd_valid = cmd_valid[gi];
    assign bus.cmd_a     = cmd_a[gi];
    assign bus.cmd_b     = cmd_b[gi];
    assign bus.cmd_op    = cmd_op[gi];
    assign bus.res_ready = res_ready[gi];
    assign bus.alu_c     = rc;

    assign rdy_obs[gi]  = bus.cmd_ready;
    assign busy_obs[gi] = busy;
    assign stb_obs[gi]  = {bus.alu_load1, bus.alu_load2, bus.alu_run};
    assign out_obs[gi]  = {bus.cmd_ready, bus.res_valid, bus.res_data, bus.res_err, busy,
                           bus.alu_a, bus.alu_b, bus.alu_op_code,
                           bus.alu_load1, bus.alu_load2, bus.alu_run};

    alu_op_sequencer #(
      .PULSE_W  (1),
      .GAP_W    (1),
      .SETTLE_W (2),
      .CACHE_EN ((gi == 0) ? 1 : 0)
    ) u_dut (
      .clk   (clk),
      .reset (rst[gi]),
      .bus   (bus),
      .busy  (busy)
    );

    // Behavioural ALU: registers capture on the falling edge of each strobe.
    always @(negedge bus.alu_load1) ra = bus.alu_a;
    always @(negedge bus.alu_load2) rb = bus.alu_b;
    always @(negedge bus.alu_run)   rc = alu_f(ra, rb, bus.alu_op_code);

    // Monitor: cycle 0 is the accept cycle.
    int   cyc, l1c, l2c, rnc, n1, n2, nr;
    bit   act, seen;
    logic pl1, pl2, prn;
    exp_t e;

    always @(negedge clk) begin
      if (rst[gi]) begin
        act = 1'b0; seen = 1'b0;
        pl1 = 1'b0; pl2 = 1'b0; prn = 1'b0;
      end else begin
        chk("strobe_exclusive",
            32'(({1'b0, bus.alu_load1} + {1'b0, bus.alu_load2} + {1'b0, bus.alu_run}) <= 2'd1), 1);
        if (act) begin
          cyc++;
          if (bus.alu_load1 && !pl1) begin n1++; if (l1c == 0) l1c = cyc; end
          if (bus.alu_load2 && !pl2) begin n2++; if (l2c == 0) l2c = cyc; end
          if (bus.alu_run   && !prn) begin nr++; if (rnc == 0) rnc = cyc; end
          if (bus.res_valid) begin
            chk("result_expected", 32'(sb_q[gi].size() > 0), 1);
            if (sb_q[gi].size() > 0) begin
              e = sb_q[gi][0];
              if (!seen) begin
                seen = 1'b1;
                chk("latency",     cyc, e.lat);
                chk("load1_cycle", l1c, e.l1c);
                chk("load2_cycle", l2c, e.l2c);
                chk("run_cycle",   rnc, e.rnc);
                chk("load1_count", n1,  e.n1);
                chk("load2_count", n2,  e.n2);
                chk("run_count",   nr,  e.nr);
              end
              chk("res_data",      bus.res_data,  e.data);
              chk("res_err",       bus.res_err,   e.err);
              chk("cmd_ready_done", bus.cmd_ready, 0);
              chk("busy_done",     busy,          1);
              if (bus.res_ready) begin
                void'(sb_q[gi].pop_front());
                act  = 1'b0;
                seen = 1'b0;
              end
            end
          end
        end else begin
          chk("stray_res_valid", bus.res_valid, 0);
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          act = 1'b1; seen = 1'b0; cyc = 0;
          l1c = 0; l2c = 0; rnc = 0; n1 = 0; n2 = 0; nr = 0;
        end
        pl1 = bus.alu_load1; pl2 = bus.alu_load2; prn = bus.alu_run;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns #1 after the accepting edge, i.e. early in cycle 1.
  task automatic issue(input int d, input logic [2:0] a, input logic [2:0] b,
                       input logic [3:0] op, input bit push, input exp_t e);
    int k = 0;
    while ((rdy_obs[d] !== 1'b1) && (k < 50)) begin
      @(posedge clk); #1; k++;
    end
    chk("cmd_ready_timeout", 32'(k < 50), 1);
    cmd_a[d] = a; cmd_b[d] = b; cmd_op[d] = op;
    cmd_valid[d] = 1'b1;
    if (push) sb_q[d].push_back(e);
    @(posedge clk); #1;
    cmd_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int k = 0;
    while ((sb_q[d].size() != 0) && (k < 100)) begin
      @(posedge clk); #1; k++;
    end
    chk("result_timeout", 32'(k < 100), 1);
  endtask

  initial begin
    cmd_a = '0; cmd_b = '0; cmd_op = '0;
    rst = 2'b11;
    cycles(3);
    chk("reset_outputs_0", out_obs[0], 0);
    chk("reset_outputs_1", out_obs[1], 0);
    rst = 2'b00;
    cycles(2);
    chk("idle_cmd_ready", rdy_obs[0], 1);
    chk("idle_busy",      busy_obs[0], 0);

    // Cache-enabled instance
    issue(0, 3'd5, 3'd2, OP_MUL, 1, mk(4'b1010, 1'b0, 9, 1, 3, 5, 1, 1, 1)); wait_done(0);
    issue(0, 3'd5, 3'd2, OP_OR,  1, mk(4'b0111, 1'b0, 5, 0, 0, 1, 0, 0, 1)); wait_done(0);
    issue(0, 3'd5, 3'd4, OP_OR,  1, mk(4'b0101, 1'b0, 7, 0, 1, 3, 0, 1, 1)); wait_done(0);

    // Illegal op held under backpressure; must not disturb the cache.
    res_ready[0] = 1'b0;
    issue(0, 3'd1, 3'd1, 4'b1100, 1, mk(4'b0000, 1'b1, 1, 0, 0, 0, 0, 0, 0));
    cycles(4);
    res_ready[0] = 1'b1;
    wait_done(0);
    issue(0, 3'd5, 3'd4, OP_ADD, 1, mk(4'd9, 1'b0, 5, 0, 0, 1, 0, 0, 1)); wait_done(0);

    // Idle with cmd_valid low
    cycles(3);
    chk("idle_hold_busy",   busy_obs[0], 0);
    chk("idle_hold_ready",  rdy_obs[0],  1);
    chk("idle_hold_strobe", stb_obs[0],  0);

    // Reset during LD2
    issue(0, 3'd7, 3'd1, OP_ADD, 0, mk(4'd0, 1'b0, 0, 0, 0, 0, 0, 0, 0));
    cycles(2);
    chk("ld2_before_reset", stb_obs[0], 3'b010);
    rst[0] = 1'b1;
    #1;
    chk("midop_reset_outputs", out_obs[0], 0);
    cycles(2);
    rst[0] = 1'b0;
    issue(0, 3'd5, 3'd2, OP_MUL, 1, mk(4'b1010, 1'b0, 9, 1, 3, 5, 1, 1, 1)); wait_done(0);

    // Cache-disabled instance: repeated operands still reload.
    issue(1, 3'd5, 3'd2, OP_MUL, 1, mk(4'b1010, 1'b0, 9, 1, 3, 5, 1, 1, 1)); wait_done(1);
    issue(1, 3'd5, 3'd2, OP_OR,  1, mk(4'b0111, 1'b0, 9, 1, 3, 5, 1, 1, 1)); wait_done(1);

    cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
